// File: rtl/lcd_hd44780_responder.sv
// HD44780-style LCD bus responder: instruction/data decode, 128-byte DDRAM, busy timing.
// Optional bus reads (status and DDRAM) are built when LCD_RESP_READ_EN is defined.
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_db_in,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  input  logic [6:0] scan_addr,
  output logic [7:0] scan_data,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       err_busy_write
);

  localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [10:0]      sync1_q, sync2_q;
  logic             en_prev_q;
  logic             cap_rs_q, cap_rw_q;
  logic [7:0]       cap_db_q;
  logic [6:0]       ac_q;
  logic             inc_q;
  logic             disp_q, cur_q, blink_q;
  logic             err_q;
  logic             cmd_valid_q;
  logic [7:0]       cmd_code_q;
  logic [CNT_W-1:0] busy_cnt_q;
  logic             clr_active_q;
  logic [6:0]       clr_ptr_q;
  logic [7:0]       func_set_unused_q;
  logic             entry_shift_unused_q;

  logic [7:0] mem_q [0:127];
  logic [7:0] rd_data_q;

  logic       en_s, rs_s, rw_s;
  logic [7:0] db_s;
  logic       fall, busy_w, wr_ok, wr_busy, instr_wr, data_wr;
  logic [6:0] ac_step;
  logic       mem_we;
  logic [6:0] mem_waddr, rd_addr;
  logic [7:0] mem_wdata;

  assign en_s     = sync2_q[10];
  assign rs_s     = sync2_q[9];
  assign rw_s     = sync2_q[8];
  assign db_s     = sync2_q[7:0];
  assign fall     = en_prev_q & ~en_s;
  assign busy_w   = (busy_cnt_q != '0);
  assign wr_ok    = fall & ~cap_rw_q & ~busy_w;
  assign wr_busy  = fall & ~cap_rw_q & busy_w;
  assign instr_wr = wr_ok & ~cap_rs_q;
  assign data_wr  = wr_ok & cap_rs_q;
  assign ac_step  = inc_q ? ac_q + 7'd1 : ac_q - 7'd1;

  // Clear walk and bus data writes never overlap: a write during the walk is a busy write.
  assign mem_we    = reset_reset_n & (clr_active_q | data_wr);
  assign mem_waddr = clr_active_q ? clr_ptr_q : ac_q;
  assign mem_wdata = clr_active_q ? 8'h20 : cap_db_q;

`ifdef LCD_RESP_READ_EN
  logic       bus_rd, rd_bus_q, db_oe_q;
  logic [7:0] db_out_q, scan_hold_q;
  logic       rd_data_ev;
  assign bus_rd     = en_s & rw_s & rs_s;
  assign rd_data_ev = fall & cap_rw_q & cap_rs_q;
  assign rd_addr    = bus_rd ? ac_q : scan_addr;
  assign scan_data  = rd_bus_q ? scan_hold_q : rd_data_q;
  assign lcd_db_out = db_out_q;
  assign lcd_db_oe  = db_oe_q;
`else
  assign rd_addr    = scan_addr;
  assign scan_data  = rd_data_q;
  assign lcd_db_out = 8'h00;
  assign lcd_db_oe  = 1'b0;
`endif

  always_ff @(posedge clk_clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    rd_data_q <= mem_q[rd_addr];
`ifdef LCD_RESP_READ_EN
    if (!rd_bus_q) scan_hold_q <= rd_data_q;
`endif
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1_q              <= '0;
      sync2_q              <= '0;
      en_prev_q            <= 1'b0;
      cap_rs_q             <= 1'b0;
      cap_rw_q             <= 1'b0;
      cap_db_q             <= 8'h00;
      ac_q                 <= 7'd0;
      inc_q                <= 1'b1;
      disp_q               <= 1'b0;
      cur_q                <= 1'b0;
      blink_q              <= 1'b0;
      err_q                <= 1'b0;
      cmd_valid_q          <= 1'b0;
      cmd_code_q           <= 8'h00;
      busy_cnt_q           <= CNT_W'(CLEAR_CYCLES);
      clr_active_q         <= 1'b1;
      clr_ptr_q            <= 7'd0;
      func_set_unused_q    <= 8'h00;
      entry_shift_unused_q <= 1'b0;
`ifdef LCD_RESP_READ_EN
      rd_bus_q             <= 1'b0;
      db_oe_q              <= 1'b0;
      db_out_q             <= 8'h00;
`endif
    end else begin
      sync1_q     <= {lcd_en, lcd_rs, lcd_rw, lcd_db_in};
      sync2_q     <= sync1_q;
      en_prev_q   <= en_s;
      cmd_valid_q <= 1'b0;
      if (en_s) {cap_rs_q, cap_rw_q, cap_db_q} <= {rs_s, rw_s, db_s};
      if (busy_w) busy_cnt_q <= busy_cnt_q - CNT_W'(1);
      if (clr_active_q) begin
        clr_ptr_q <= clr_ptr_q + 7'd1;
        if (clr_ptr_q == 7'h7F) clr_active_q <= 1'b0;
      end
      if (wr_busy) err_q <= 1'b1;
      if (data_wr) begin
        ac_q       <= ac_step;
        busy_cnt_q <= CNT_W'(BUSY_CYCLES);
      end
      if (instr_wr && cap_db_q != 8'h00) begin
        cmd_valid_q <= 1'b1;
        cmd_code_q  <= cap_db_q;
        busy_cnt_q  <= CNT_W'(BUSY_CYCLES);
        casez (cap_db_q)
          8'b1???????: ac_q <= cap_db_q[6:0];
          8'b01??????: begin end
          8'b001?????: func_set_unused_q <= cap_db_q;
          8'b0001????: if (!cap_db_q[3]) ac_q <= cap_db_q[2] ? ac_q + 7'd1 : ac_q - 7'd1;
          8'b00001???: {disp_q, cur_q, blink_q} <= cap_db_q[2:0];
          8'b000001??: begin
            inc_q                <= cap_db_q[1];
            entry_shift_unused_q <= cap_db_q[0];
          end
          8'b0000001?: begin
            ac_q       <= 7'd0;
            busy_cnt_q <= CNT_W'(CLEAR_CYCLES);
          end
          default: begin
            ac_q         <= 7'd0;
            inc_q        <= 1'b1;
            busy_cnt_q   <= CNT_W'(CLEAR_CYCLES);
            clr_active_q <= 1'b1;
            clr_ptr_q    <= 7'd0;
          end
        endcase
      end
`ifdef LCD_RESP_READ_EN
      // Bus reads borrow the scan read port; scan_data holds its last value meanwhile.
      rd_bus_q <= bus_rd;
      db_oe_q  <= en_s & rw_s;
      if (en_s && rw_s) begin
        if (!rs_s) db_out_q <= {busy_w, ac_q};
        else if (rd_bus_q) db_out_q <= rd_data_q;
      end
      if (rd_data_ev) begin
        if (busy_w) err_q <= 1'b1;
        else ac_q <= ac_step;
      end
`endif
    end
  end

  assign cursor_addr    = ac_q;
  assign disp_on        = disp_q;
  assign cursor_on      = cur_q;
  assign blink_on       = blink_q;
  assign busy           = busy_w;
  assign cmd_valid      = cmd_valid_q;
  assign cmd_code       = cmd_code_q;
  assign err_busy_write = err_q;

endmodule
